// File: rtl/vga_framebuffer_reader.sv
// ============================================================================
// Module   : vga_framebuffer_reader
// Purpose  : 640x480@60 VGA scan-out of a 320x240 RGB565 frame buffer, 2x
//            pixel/line doubled, read through a BRAM port with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_framebuffer_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int FB_WIDTH   = 320,
   parameter int RD_LATENCY = 1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [15:0] din,
   output logic [16:0] addr,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        frame_start
);

   localparam int         c_pipe_depth   = 2 + RD_LATENCY;
   localparam logic [9:0] c_h_active     = 10'(H_ACTIVE);
   localparam logic [9:0] c_h_last       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] c_h_sync_start = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] c_h_sync_end   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] c_v_active     = 10'(V_ACTIVE);
   localparam logic [9:0] c_v_last       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] c_v_sync_start = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] c_v_sync_end   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [16:0] c_fb_width    = 17'(FB_WIDTH);

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic [16:0] line_base_q, line_base_d;
   logic [16:0] addr_q, addr_d;
   logic [11:0] rgb_q, rgb_d;

   // The colour register is the final de stage, so de needs one fewer flop.
   logic [c_pipe_depth-2:0] de_pipe_q, de_pipe_d;
   logic [c_pipe_depth-1:0] hs_pipe_q, hs_pipe_d;
   logic [c_pipe_depth-1:0] vs_pipe_q, vs_pipe_d;
   logic [c_pipe_depth-1:0] fs_pipe_q, fs_pipe_d;

   logic de, hsync_n, vsync_n, fs;
   logic unused_din;

   assign unused_din = ^{din[11], din[6:5], din[0]};

   always_comb begin
      h_cnt_d     = h_cnt_q + 10'd1;
      v_cnt_d     = v_cnt_q;
      line_base_d = line_base_q;
      if (h_cnt_q == c_h_last) begin
         h_cnt_d = '0;
         if (v_cnt_q == c_v_last) begin
            v_cnt_d     = '0;
            line_base_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
            // Advance the source row only after every second display line.
            if (v_cnt_q[0]) line_base_d = line_base_q + c_fb_width;
         end
      end

      de      = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
      hsync_n = !((h_cnt_q >= c_h_sync_start) && (h_cnt_q <= c_h_sync_end));
      vsync_n = !((v_cnt_q >= c_v_sync_start) && (v_cnt_q <= c_v_sync_end));
      fs      = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

      addr_d = de ? (line_base_q + {8'd0, h_cnt_q[9:1]}) : 17'd0;

      de_pipe_d = {de_pipe_q[c_pipe_depth-3:0], de};
      hs_pipe_d = {hs_pipe_q[c_pipe_depth-2:0], hsync_n};
      vs_pipe_d = {vs_pipe_q[c_pipe_depth-2:0], vsync_n};
      fs_pipe_d = {fs_pipe_q[c_pipe_depth-2:0], fs};

      rgb_d = de_pipe_q[c_pipe_depth-2] ? {din[15:12], din[10:7], din[4:1]} : 12'd0;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         line_base_q <= '0;
         addr_q      <= '0;
         rgb_q       <= '0;
         de_pipe_q   <= '0;
         hs_pipe_q   <= '1;
         vs_pipe_q   <= '1;
         fs_pipe_q   <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         line_base_q <= line_base_d;
         addr_q      <= addr_d;
         rgb_q       <= rgb_d;
         de_pipe_q   <= de_pipe_d;
         hs_pipe_q   <= hs_pipe_d;
         vs_pipe_q   <= vs_pipe_d;
         fs_pipe_q   <= fs_pipe_d;
      end
   end

   assign addr        = addr_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign vga_hsync   = hs_pipe_q[c_pipe_depth-1];
   assign vga_vsync   = vs_pipe_q[c_pipe_depth-1];
   assign frame_start = fs_pipe_q[c_pipe_depth-1];

endmodule

`default_nettype wire

// File: tb/tb_vga_framebuffer_reader.sv
// ============================================================================
// Module   : tb_vga_framebuffer_reader
// Purpose  : Directed bench: full-size reader (latency 1, constant BRAM) and a
//            short-frame reader (latency 2, address-echo BRAM).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_framebuffer_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] din_a = 16'd0;
   logic [15:0] din_b = 16'd0;
   logic [16:0] rd_pipe_b = 17'd0;
   logic [16:0] addr_a, addr_b;
   logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
   logic        hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #20 clk = ~clk;

   vga_framebuffer_reader #(.RD_LATENCY(1)) dut_a (
      .pclk(clk), .rst(rst), .din(din_a), .addr(addr_a),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
      .vga_hsync(hs_a), .vga_vsync(vs_a), .frame_start(fs_a)
   );

   vga_framebuffer_reader #(
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .RD_LATENCY(2)
   ) dut_b (
      .pclk(clk), .rst(rst), .din(din_b), .addr(addr_b),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
      .vga_hsync(hs_b), .vga_vsync(vs_b), .frame_start(fs_b)
   );

   always @(posedge clk) din_a <= 16'hF81F;

   always @(posedge clk) begin
      rd_pipe_b <= addr_b;
      din_b     <= rd_pipe_b[15:0];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected read address for counter cycle c (800 clocks per line).
   function automatic logic [16:0] fb_addr(input int c, input int v_act, input int v_tot);
      int h, v;
      h = c % 800;
      v = (c / 800) % v_tot;
      if (h < 640 && v < v_act) return 17'((v / 2) * 320 + h / 2);
      return 17'd0;
   endfunction

   // Expected {rgb, hsync, vsync, frame_start} at output cycle k.
   function automatic logic [14:0] exp_out(input int k, input int lat, input int v_act,
                                           input int v_tot, input int vs_start, input logic echo);
      int c, h, v;
      logic [16:0] a;
      logic [11:0] rgb;
      logic hs, vs, fsv;
      if (k < lat) return {12'd0, 3'b110};
      c   = k - lat;
      h   = c % 800;
      v   = (c / 800) % v_tot;
      a   = fb_addr(c, v_act, v_tot);
      rgb = 12'd0;
      if (h < 640 && v < v_act) rgb = echo ? {a[15:12], a[10:7], a[4:1]} : 12'hF0F;
      hs  = !(h >= 656 && h <= 751);
      vs  = !(v >= vs_start && v <= vs_start + 1);
      fsv = (h == 0) && (v == 0);
      return {rgb, hs, vs, fsv};
   endfunction

   int err_addr_a, err_out_a, err_addr_b, err_out_b;
   int hf_a0, hf_a1, hr_a0, fs_a_cnt, fs_a_first;
   int hf_b0, vf_b0, vf_b1, vr_b0, fs_b_cnt, fs_b0, fs_b1;
   int max_addr_b;
   logic prev_hs_a, prev_hs_b, prev_vs_b;

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      check("rst_addr_a",  addr_a, 0);
      check("rst_rgb_a",   {r_a, g_a, b_a}, 0);
      check("rst_hsync_a", hs_a, 1);
      check("rst_vsync_a", vs_a, 1);
      check("rst_fs_a",    fs_a, 0);
      check("rst_addr_b",  addr_b, 0);
      rst = 1'b0;

      err_addr_a = 0; err_out_a = 0; err_addr_b = 0; err_out_b = 0;
      hf_a0 = -1; hf_a1 = -1; hr_a0 = -1; fs_a_cnt = 0; fs_a_first = -1;
      hf_b0 = -1; vf_b0 = -1; vf_b1 = -1; vr_b0 = -1; fs_b_cnt = 0; fs_b0 = -1; fs_b1 = -1;
      max_addr_b = 0;
      prev_hs_a = hs_a; prev_hs_b = hs_b; prev_vs_b = vs_b;

      for (int k = 1; k <= 13000; k++) begin
         tick();
         if (addr_a !== fb_addr(k - 1, 480, 525)) err_addr_a++;
         if ({r_a, g_a, b_a, hs_a, vs_a, fs_a} !== exp_out(k, 3, 480, 525, 490, 1'b0)) err_out_a++;
         if (addr_b !== fb_addr(k - 1, 4, 8)) err_addr_b++;
         if ({r_b, g_b, b_b, hs_b, vs_b, fs_b} !== exp_out(k, 4, 4, 8, 5, 1'b1)) err_out_b++;
         if (int'(addr_b) > max_addr_b) max_addr_b = int'(addr_b);

         if (prev_hs_a && !hs_a) begin
            if (hf_a0 < 0) hf_a0 = k; else if (hf_a1 < 0) hf_a1 = k;
         end
         if (!prev_hs_a && hs_a && hr_a0 < 0) hr_a0 = k;
         if (fs_a) begin
            fs_a_cnt++;
            if (fs_a_first < 0) fs_a_first = k;
         end
         if (prev_hs_b && !hs_b && hf_b0 < 0) hf_b0 = k;
         if (prev_vs_b && !vs_b) begin
            if (vf_b0 < 0) vf_b0 = k; else if (vf_b1 < 0) vf_b1 = k;
         end
         if (!prev_vs_b && vs_b && vr_b0 < 0) vr_b0 = k;
         if (fs_b) begin
            fs_b_cnt++;
            if (fs_b0 < 0) fs_b0 = k; else if (fs_b1 < 0) fs_b1 = k;
         end
         prev_hs_a = hs_a; prev_hs_b = hs_b; prev_vs_b = vs_b;

         if (k == 3)    check("a_addr_row0_h2",   addr_a, 1);
         if (k == 3)    check("a_rgb_first_px",   {r_a, g_a, b_a}, 12'hF0F);
         if (k == 641)  check("a_addr_hblank",    addr_a, 0);
         if (k == 1601) check("a_addr_row2_h0",   addr_a, 320);
         if (k == 2240) check("a_addr_row2_h639", addr_a, 639);
         if (k == 404)  check("b_rgb_px400_row0", {r_b, g_b, b_b}, 12'h014);
         if (k == 642)  check("b_rgb_px638_row0", {r_b, g_b, b_b}, 12'h02F);
         if (k == 1604) check("b_rgb_px0_row2",   {r_b, g_b, b_b}, 12'h020);
         if (k == 6804) check("b_rgb_frame2_px400", {r_b, g_b, b_b}, 12'h014);
      end

      check("a_addr_trace_errs",  err_addr_a, 0);
      check("a_output_errs",      err_out_a, 0);
      check("b_addr_trace_errs",  err_addr_b, 0);
      check("b_output_errs",      err_out_b, 0);
      check("a_hsync_first_fall", hf_a0, 659);
      check("a_hsync_period",     hf_a1 - hf_a0, 800);
      check("a_hsync_low_width",  hr_a0 - hf_a0, 96);
      check("a_fs_first",         fs_a_first, 3);
      check("a_fs_count",         fs_a_cnt, 1);
      check("b_hsync_first_fall", hf_b0, 660);
      check("b_fs_first",         fs_b0, 4);
      check("b_fs_period",        fs_b1 - fs_b0, 6400);
      check("b_fs_count",         fs_b_cnt, 3);
      check("b_vsync_first_fall", vf_b0, 4004);
      check("b_vsync_period",     vf_b1 - vf_b0, 6400);
      check("b_vsync_low_width",  vr_b0 - vf_b0, 1600);
      check("b_max_addr",         max_addr_b, 639);

      // Land mid-line in an active row, then pulse reset for one cycle.
      repeat (100) tick();
      check("pre_rst_addr_nonzero", addr_a != 17'd0, 1);
      rst = 1'b1;
      tick();
      check("mid_rst_addr", addr_a, 0);
      check("mid_rst_rgb",  {r_a, g_a, b_a}, 0);
      check("mid_rst_hsync", hs_a, 1);
      rst = 1'b0;

      err_addr_a = 0; err_out_a = 0; err_out_b = 0;
      fs_a_cnt = 0; fs_a_first = -1; hf_a0 = -1;
      prev_hs_a = hs_a;
      for (int k = 1; k <= 700; k++) begin
         tick();
         if (addr_a !== fb_addr(k - 1, 480, 525)) err_addr_a++;
         if ({r_a, g_a, b_a, hs_a, vs_a, fs_a} !== exp_out(k, 3, 480, 525, 490, 1'b0)) err_out_a++;
         if ({r_b, g_b, b_b, hs_b, vs_b, fs_b} !== exp_out(k, 4, 4, 8, 5, 1'b1)) err_out_b++;
         if (prev_hs_a && !hs_a && hf_a0 < 0) hf_a0 = k;
         if (fs_a) begin
            fs_a_cnt++;
            if (fs_a_first < 0) fs_a_first = k;
         end
         prev_hs_a = hs_a;
         if (k == 2) check("mid_rst_flushed_rgb", {r_a, g_a, b_a}, 0);
      end

      check("mid_rst_addr_errs",  err_addr_a, 0);
      check("mid_rst_out_errs_a", err_out_a, 0);
      check("mid_rst_out_errs_b", err_out_b, 0);
      check("mid_rst_fs_first",   fs_a_first, 3);
      check("mid_rst_fs_count",   fs_a_cnt, 1);
      check("mid_rst_hsync_fall", hf_a0, 659);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vga_framebuffer_reader.md
Name: vga_framebuffer_reader

Overview:
- Display-side reader of the 320x240 RGB565 frame buffer that the camera capture path writes (addresses 0..76799).
- Generates 640x480@60 VGA timing on a 25 MHz pixel clock.
- Reads the buffer through the BRAM's second port and upscales 2x in both axes by pixel and line doubling.
- Drives 4-bit-per-channel colour plus active-low hsync/vsync to the board VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
FB_WIDTH, 320, frame buffer line length in pixels
RD_LATENCY, 1, BRAM read latency in cycles (1 or 2)

Ports:
pclk  in  1  25 MHz pixel clock
rst  in  1  synchronous reset, active-high
din  in  16  BRAM read data, RGB565
addr  out  17  BRAM read address
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_hsync  out  1  horizontal sync, active low
vga_vsync  out  1  vertical sync, active low
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Single clock domain is pclk. rst is synchronous and active-high.
- Reset values:
  - h_cnt=0, v_cnt=0, line_base=0, addr=0.
  - vga_r/g/b=0, vga_hsync=1, vga_vsync=1, frame_start=0.
  - All delay-pipe stages cleared to blank, sync high.
- Counters:
  - h_cnt runs 0..799, incrementing every cycle.
  - At 799, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt runs 0..524 and wraps to 0 after line 524 ends (frame = 420000 cycles).
- Active region: de = (h_cnt<640) && (v_cnt<480).
- Sync decode, from counters:
  - hsync_n = 0 for h_cnt in 656..751.
  - vsync_n = 0 for v_cnt in 490..491.
- Address generation (no multiplier):
  - line_base increments by FB_WIDTH at each h wrap where v_cnt[0]==1.
  - line_base clears to 0 at frame wrap.
  - addr is registered: addr <= de ? line_base + h_cnt[9:1] : 0.
  - addr never exceeds 76799; it is held at 0 throughout blanking.
- Pipeline timing:
  - Counters (h,v) at cycle t produce addr at t+1.
  - din is valid at t+1+RD_LATENCY.
  - Colour outputs are registered at t+2+RD_LATENCY.
  - de, hsync_n and vsync_n pass through a delay pipe of 2+RD_LATENCY stages so sync and colour stay aligned.
- Colour mapping, when delayed de=1:
  - vga_r=din[15:12], vga_g=din[10:7], vga_b=din[4:1].
  - When delayed de=0, all colours are 0.
- frame_start:
  - Asserted for exactly one cycle, in the same cycle the pixel for (h=0,v=0) appears on the colour outputs.
  - First pulse comes 2+RD_LATENCY cycles after rst deasserts.
- Reset mid-frame:
  - Counters restart at (0,0) on the cycle after rst falls.
  - The delay pipe is flushed; no partial line is emitted.
  - Sync outputs stay high until their decoded windows are reached.
- No handshake with the writer:
  - Tearing is accepted.
  - The reader never stalls and never writes.

Test Plan:
- Reset, then run 2 lines, RD_LATENCY=1 -> vga_hsync period 800 cycles; low for 96 cycles, first falling edge 656+3=659 cycles after rst deasserts.
- Run 2 full frames -> vga_vsync period 420000 cycles, low for exactly 1600 cycles, falling edge at line 490; frame_start pulses once per frame, first at cycle 3.
- Address trace -> row 0 gives 0,0,1,1,...,319,319; row 1 repeats 0..319; row 2 starts at 320; row 479 ends at 76799; addr=0 in all blanking; max addr never above 76799.
- BRAM model returning din=16'hF81F for all addresses -> active pixels r=F, g=0, b=F; blanking pixels r=g=b=0; colour transitions exactly on delayed de edges.
- Assert rst for 1 cycle at v_cnt=200, h_cnt=300 -> the next frame_start occurs 3 cycles after rst falls; the addr sequence restarts at 0; no sync glitch shorter than its nominal width.
- RD_LATENCY=2 with an addr-echo BRAM model (din=addr) -> colour output at pixel (2k,0) equals the truncated bits of k; hsync falling edge at cycle 660; frame_start at cycle 4.
